rr_arbiter8: RTL and testbench
==============================

// Module: rr_arbiter8
// PURPOSE
//   Round-robin arbiter sharing one resource between 8 requesters.
//   Picks a winner index (3-bit), latches it, and drives a one-hot grant
//   vector through the team's 3:8 decode function.
//   Sits between requesting sub-blocks and a shared bus/ALU port.
//   Holder keeps grant until it drops its request.
// PARAMETERS
//   MAX_HOLD  16  max consecutive GRANT cycles before forced rotation (ARB_TIMEOUT_EN only)
//   CNT_W     5   hold-counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//   clk        in   1  single clock, all state on rising edge
//   rst_n      in   1  asynchronous, active-low reset
//   req        in   8  request per requester, level-sensitive
//   gnt        out  8  one-hot grant, registered; bit k = 1 << gnt_idx
//   gnt_idx    out  3  encoded index of current holder
//   gnt_valid  out  1  1 while any grant is active (== |gnt)
//   timeout    out  1  1-cycle pulse when a forced rotation occurs
// BEHAVIOUR
// - Reset (async, rst_n=0): gnt=0, gnt_idx=0, gnt_valid=0, timeout=0,
//   state=IDLE, ptr=0, hold_cnt=0. Reset mid-grant drops gnt immediately.
// - ptr[2:0] = search start index; priority order ptr, ptr+1, ... ptr+7 (mod 8).
// - FSM states:
//   IDLE : gnt=0. If req!=0 at edge -> GRANT, winner = first set bit
//          from ptr. Latency: req high at edge N -> gnt high after edge N.
//   GRANT: holder = gnt_idx.
//          req[gnt_idx]=1 -> stay, gnt unchanged, hold_cnt++ (saturates).
//          req[gnt_idx]=0 -> ptr <= gnt_idx+1 (wraps 7->0); arbitrate
//            req with holder bit masked out, starting at gnt_idx+1:
//            winner found -> stay GRANT with new idx (no bubble cycle);
//            none         -> IDLE, gnt=0 next cycle.
//          hold_cnt cleared on every new grant.
// - Arbitration is purely combinational on the sampled req; gnt only
//   changes on clock edges, never glitches mid-cycle.
// - Only one gnt bit ever set; gnt_valid==|gnt at all times.
// - Requests that drop before being granted are simply not served.
// - Simultaneous drop of holder and rise of others: others arbitrated
//   same edge per rule above.
// - Wrap-around: holder 7 releasing -> search starts at 0.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined:
//     in GRANT, when hold_cnt==MAX_HOLD-1 and req has any bit other than
//     holder set -> forced rotation at that edge: holder treated as
//     released (masked), next winner granted, ptr <= gnt_idx+1,
//     timeout pulses 1 for exactly the following cycle.
//     No other requester pending -> holder keeps grant, hold_cnt saturates
//     at MAX_HOLD-1, no timeout pulse; rotation fires as soon as one appears.
//   ARB_TIMEOUT_EN undefined:
//     no hold_cnt logic; timeout tied 0; grant held indefinitely.
// TESTING
//   1 rst_n=0 while req=8'hFF -> gnt=0, gnt_idx=0, gnt_valid=0; release
//     reset -> after 1st edge gnt=8'h01.
//   2 req=8'h24 from IDLE, ptr=0 -> gnt=8'h04, idx=2; drop req[2]
//     -> next edge gnt=8'h20, idx=5 (no idle cycle).
//   3 req=8'hFF, each holder drops for 1 cycle after grant -> grant order
//     0,1,...,7,0 (wrap verified), never two bits set.
//   4 holder idx=7, req=8'h81, drop req[7] -> gnt=8'h01; ptr=0.
//   5 ARB_TIMEOUT_EN, MAX_HOLD=4: req=8'h03 held -> gnt=8'h01 for 4 cycles,
//     then gnt=8'h02 with timeout=1 one cycle; req=8'h01 alone -> no timeout.
//   6 assert rst_n=0 mid-GRANT (gnt=8'h10) -> gnt=0 asynchronously, ptr=0.

Source files
------------

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant.
// Optional hold-time limit with forced rotation when ARB_TIMEOUT_EN is defined.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] others;
  logic [3:0] idle_pick;
  logic [3:0] next_pick;
  logic       forced;
  logic       release_now;

  function automatic logic [7:0] dec3to8(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

  // Walk from the farthest offset back to the start so the nearest set bit wins.
  function automatic logic [3:0] find_first(input logic [7:0] r, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  logic [CNT_W-1:0] hold_cnt;
  assign forced = req[gnt_idx] && (hold_cnt == HOLD_LAST) && (others != 8'h00);
`else
  logic [CNT_W-1:0] unused_cfg;
  assign unused_cfg = CNT_W'(MAX_HOLD);
  assign forced     = 1'b0;
`endif

  always_comb begin
    others      = req & ~dec3to8(gnt_idx);
    idle_pick   = find_first(req, ptr);
    next_pick   = find_first(others, gnt_idx + 3'd1);
    release_now = ~req[gnt_idx] | forced;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (idle_pick[3]) begin
            state     <= GRANT;
            gnt_idx   <= idle_pick[2:0];
            gnt       <= dec3to8(idle_pick[2:0]);
            gnt_valid <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end
        end
        GRANT: begin
          if (release_now) begin
            // Hand over on the same edge so there is no idle bubble between holders.
            ptr     <= gnt_idx + 3'd1;
            timeout <= forced;
            if (next_pick[3]) begin
              gnt_idx   <= next_pick[2:0];
              gnt       <= dec3to8(next_pick[2:0]);
              gnt_valid <= 1'b1;
`ifdef ARB_TIMEOUT_EN
              hold_cnt  <= '0;
`endif
            end else begin
              state     <= IDLE;
              gnt       <= 8'h00;
              gnt_valid <= 1'b0;
            end
          end else begin
            timeout <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + CNT_W'(1);
`endif
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= 8'h00;
          gnt_valid <= 1'b0;
          timeout   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed scoreboard bench for rr_arbiter8; also covers ARB_TIMEOUT_EN
// behaviour (MAX_HOLD=4) when that macro is defined for the build.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] gnt;
    logic       to;
    string      tag;
  } exp_t;

  exp_t sb[$];

  rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [7:0] exp_idx;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard: observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    exp_idx = 8'h00;
    for (int i = 0; i < 8; i++) if (e.gnt[i]) exp_idx = 8'(i);
    cmp({e.tag, ".gnt"}, gnt, e.gnt);
    cmp({e.tag, ".valid"}, {7'b0, gnt_valid}, {7'b0, (e.gnt != 8'h00)});
    cmp({e.tag, ".timeout"}, {7'b0, timeout}, {7'b0, e.to});
    cmp({e.tag, ".onehot"}, {7'b0, $onehot0(gnt)}, 8'h01);
    if (e.gnt != 8'h00) cmp({e.tag, ".idx"}, {5'b0, gnt_idx}, exp_idx);
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] exp_gnt,
                               input logic exp_to, input string tag);
    exp_t e;
    @(negedge clk);
    req = r;
    e.gnt = exp_gnt;
    e.to  = exp_to;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Reset is applied between edges so the grant must clear without a clock.
  task automatic doReset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    cmp({tag, ".async_gnt"}, gnt, 8'h00);
    cmp({tag, ".async_valid"}, {7'b0, gnt_valid}, 8'h00);
    cmp({tag, ".async_idx"}, {5'b0, gnt_idx}, 8'h00);
    cmp({tag, ".async_to"}, {7'b0, timeout}, 8'h00);
    @(negedge clk);
    req   = 8'h00;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;

    // Reset held with every request active
    repeat (2) @(posedge clk);
    #1;
    cmp("rst.gnt", gnt, 8'h00);
    cmp("rst.idx", {5'b0, gnt_idx}, 8'h00);
    cmp("rst.valid", {7'b0, gnt_valid}, 8'h00);
    cmp("rst.timeout", {7'b0, timeout}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'hFF, 8'h01, 1'b0, "rst_release");

    // Direct handover 2 -> 5 with no idle cycle, then back to idle
    doReset("r2");
    applyStimulus(8'h24, 8'h04, 1'b0, "t2.first");
    applyStimulus(8'h20, 8'h20, 1'b0, "t2.handover");
    applyStimulus(8'h00, 8'h00, 1'b0, "t2.idle");

    // Full rotation with wrap back to requester 0
    doReset("r3");
    applyStimulus(8'hFF, 8'h01, 1'b0, "t3.start");
    for (int k = 1; k <= 8; k++)
      applyStimulus(8'hFF & ~(8'h01 << (k - 1)), 8'h01 << (k % 8), 1'b0, $sformatf("t3.rot%0d", k));

    // Holder 7 releasing wraps the search to 0
    doReset("r4");
    applyStimulus(8'h80, 8'h80, 1'b0, "t4.grant7");
    applyStimulus(8'h81, 8'h80, 1'b0, "t4.hold7");
    applyStimulus(8'h01, 8'h01, 1'b0, "t4.wrap");
    doReset("r4b");
    applyStimulus(8'h80, 8'h80, 1'b0, "t4b.grant7");
    applyStimulus(8'h06, 8'h02, 1'b0, "t4b.wrap_from0");

`ifdef ARB_TIMEOUT_EN
    doReset("r5");
    applyStimulus(8'h03, 8'h01, 1'b0, "t5.hold1");
    applyStimulus(8'h03, 8'h01, 1'b0, "t5.hold2");
    applyStimulus(8'h03, 8'h01, 1'b0, "t5.hold3");
    applyStimulus(8'h03, 8'h01, 1'b0, "t5.hold4");
    applyStimulus(8'h03, 8'h02, 1'b1, "t5.forced");
    applyStimulus(8'h03, 8'h02, 1'b0, "t5.pulse_end");
    applyStimulus(8'h01, 8'h01, 1'b0, "t5.release");
    for (int k = 0; k < 8; k++)
      applyStimulus(8'h01, 8'h01, 1'b0, $sformatf("t5.alone%0d", k));
    applyStimulus(8'h05, 8'h04, 1'b1, "t5.late_rival");
`else
    doReset("r5");
    applyStimulus(8'h03, 8'h01, 1'b0, "t5.grant");
    for (int k = 0; k < 20; k++)
      applyStimulus(8'h03, 8'h01, 1'b0, $sformatf("t5.hold%0d", k));
`endif

    // Reset mid-grant, then arbitration restarts from requester 0
    doReset("r6");
    applyStimulus(8'h10, 8'h10, 1'b0, "t6.grant4");
    applyStimulus(8'h10, 8'h10, 1'b0, "t6.hold4");
    doReset("r6mid");
    applyStimulus(8'hFF, 8'h01, 1'b0, "t6.ptr0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
